// File: rtl/fetch_sequencer.sv
// Instruction-fetch controller: owns the PC, registers fetched words into a valid/ready stage,
// honours redirects and runs START_PC..DEPTH-1 to done. Optional macro FETCH_WRAP_EN loops the program.
module fetch_sequencer #(
    parameter int AW       = 3,
    parameter int DEPTH    = 5,
    parameter int START_PC = 0,
    parameter int CW       = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    output logic [AW-1:0] imem_addr,
    input  logic [31:0]   imem_rd,
    output logic [31:0]   inst,
    output logic [AW-1:0] inst_pc,
    output logic          inst_valid,
    input  logic          inst_ready,
    input  logic          redirect,
    input  logic [AW-1:0] redirect_pc,
    output logic          done,
    output logic          fault,
    output logic [CW-1:0] retired,
    output logic [1:0]    state
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] FETCH = 2'd1;
    localparam logic [1:0] DRAIN = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;

    localparam logic [AW-1:0] START_V   = AW'(START_PC);
    localparam logic [AW-1:0] LAST_PC   = AW'(DEPTH - 1);
    // One extra bit so DEPTH == 2**AW still compares correctly against a redirect target.
    localparam logic [AW:0]   DEPTH_EXT = (AW + 1)'(DEPTH);
    localparam logic [CW-1:0] RET_MAX   = {CW{1'b1}};

    logic [AW-1:0] pc;
    logic          handshake;
    logic          capture;
    logic          target_ok;
    logic          active;

    // Output stage: inst/inst_pc are stable while inst_valid && !inst_ready; a word moves to
    // decode only at a rising edge with inst_valid && inst_ready, and is never withdrawn except by
    // redirect or reset.
    assign handshake = inst_valid && inst_ready;
    assign capture   = !inst_valid || inst_ready;
    assign target_ok = {1'b0, redirect_pc} < DEPTH_EXT;
    assign active    = (state == FETCH) || (state == DRAIN);
    assign imem_addr = pc;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            pc         <= '0;
            inst       <= '0;
            inst_pc    <= '0;
            inst_valid <= 1'b0;
            done       <= 1'b0;
            fault      <= 1'b0;
        end else if (active && redirect) begin
            inst_valid <= 1'b0;
            if (target_ok) begin
                pc    <= redirect_pc;
                state <= FETCH;
            end else begin
                state <= DONE;
                done  <= 1'b1;
                fault <= 1'b1;
            end
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state <= FETCH;
                        pc    <= START_V;
                        done  <= 1'b0;
                        fault <= 1'b0;
                    end
                end
                FETCH: begin
                    if (capture) begin
                        inst       <= imem_rd;
                        inst_pc    <= pc;
                        inst_valid <= 1'b1;
                        if (pc == LAST_PC) begin
`ifdef FETCH_WRAP_EN
                            pc <= '0;
`else
                            state <= DRAIN;
`endif
                        end else begin
                            pc <= pc + AW'(1);
                        end
                    end
                end
                DRAIN: begin
                    if (handshake) begin
                        inst_valid <= 1'b0;
                        state      <= DONE;
                        done       <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // A handshake coincident with a redirect still counts; start clears only from IDLE/DONE.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            retired <= '0;
        end else if (!active && start) begin
            retired <= '0;
        end else if (handshake && (retired != RET_MAX)) begin
            retired <= retired + CW'(1);
        end
    end

endmodule
